// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states,
// RV32I funct3 encodings and the byte-lane select width.
package lsu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RMW_READ,
    WRITE,
    RESP
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int LANE_SEL_W = 2;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: extracts and extends load data from a RAM word,
// and merges sub-word store data into a RAM word for read-modify-write.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0]           word_i,
  input  logic [31:0]           wdata_i,
  input  logic [LANE_SEL_W-1:0] lane_i,
  input  logic [2:0]            funct3_i,
  output logic [31:0]           load_data_o,
  output logic [31:0]           merged_o
);

  logic [4:0]  byteShamt;
  logic [4:0]  halfShamt;
  logic [31:0] shiftedWord;
  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  assign byteShamt   = {lane_i, 3'b000};
  assign halfShamt   = {lane_i[1], 4'b0000};
  assign shiftedWord = word_i >> byteShamt;
  assign byteSel     = shiftedWord[7:0];
  assign halfSel     = lane_i[1] ? word_i[31:16] : word_i[15:0];

  always_comb begin
    load_data_o = '0;
    unique case (funct3_i)
      F3_B:    load_data_o = {{24{byteSel[7]}}, byteSel};
      F3_H:    load_data_o = {{16{halfSel[15]}}, halfSel};
      F3_W:    load_data_o = word_i;
      F3_BU:   load_data_o = {24'h0, byteSel};
      F3_HU:   load_data_o = {16'h0, halfSel};
      default: load_data_o = '0;
    endcase
  end

  // Lanes outside the addressed byte/half keep the RAM contents.
  always_comb begin
    merged_o = wdata_i;
    unique case (funct3_i)
      F3_B: merged_o = (word_i & ~(32'h0000_00FF << byteShamt))
                     | ({24'h0, wdata_i[7:0]} << byteShamt);
      F3_H: merged_o = (word_i & ~(32'h0000_FFFF << halfShamt))
                     | ({16'h0, wdata_i[15:0]} << halfShamt);
      default: merged_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store front-end between the CPU and a word-addressed RAM:
// sub-word loads with extension, read-modify-write stores, access checking.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wr_en,
  input  logic [31:0] mem_rdata
);

  localparam logic [29:0] MaxWord = 30'(MEM_WORDS);

  lsu_state_e  state_q, state_d;
  logic        store_q, store_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] word_q, word_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        illegalF3;
  logic        misaligned;
  logic        outOfRange;
  logic        reqErr;
  logic [31:0] loadData;
  logic [31:0] mergedWord;

  lsu_align u_align (
    .word_i     (mem_rdata),
    .wdata_i    (wdata_q),
    .lane_i     (addr_q[1:0]),
    .funct3_i   (funct3_q),
    .load_data_o(loadData),
    .merged_o   (mergedWord)
  );

  // Any of the three checks aborts the access before the RAM is touched.
  assign illegalF3  = req_store ? !(req_funct3 inside {F3_B, F3_H, F3_W})
                                : !(req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
  assign misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0])
                   || ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  assign outOfRange = req_addr[31:2] >= MaxWord;
  assign reqErr     = illegalF3 || misaligned || outOfRange;

  always_comb begin
    state_d  = state_q;
    store_d  = store_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    word_d   = word_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          store_d  = req_store;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          word_d   = req_wdata;
          rdata_d  = '0;
          err_d    = reqErr;
          if (reqErr)                  state_d = RESP;
          else if (!req_store)         state_d = LOAD;
          else if (req_funct3 == F3_W) state_d = WRITE;
          else                         state_d = RMW_READ;
        end
      end
      LOAD: begin
        rdata_d = loadData;
        state_d = RESP;
      end
      RMW_READ: begin
        word_d  = mergedWord;
        state_d = WRITE;
      end
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      store_q  <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      word_q   <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      store_q  <= store_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      word_q   <= word_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Gating with reset keeps a reset that lands in WRITE from corrupting RAM.
  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = (store_q || err_q) ? 32'h0 : rdata_q;
  assign resp_err   = err_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = word_q;
  assign mem_wr_en  = (state_q == WRITE) && !reset;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: RAM model preloaded with 100+i,
// expected responses queued at issue and checked when resp_valid pulses.
module tb_load_store_unit;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wr_en;
  logic [31:0] mem_rdata;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          writes;
  } exp_t;

  exp_t        expQ[$];
  int          acceptQ[$];
  int          acceptLog[$];
  logic [31:0] ram [0:63];
  int          cycleCount = 0;
  int          acceptCount = 0;
  int          writeCount = 0;
  int          writesAtLastResp = 0;
  int          assertCount = 0;
  int          failCount = 0;

  load_store_unit #(.MEM_WORDS(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_store (req_store),
    .req_funct3(req_funct3),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wr_en (mem_wr_en),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = ram[mem_addr[7:2]];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // RAM write port plus acceptance bookkeeping, sampled at the active edge.
  always @(posedge clk) begin
    cycleCount++;
    if (mem_wr_en) begin
      ram[mem_addr[7:2]] <= mem_wdata;
      writeCount++;
    end
    if (req_valid && req_ready) begin
      acceptCount++;
      acceptQ.push_back(cycleCount);
      acceptLog.push_back(cycleCount);
    end
  end

  // Response monitor on the falling edge.
  always @(negedge clk) begin
    if (acceptQ.size() > 0)
      checkOutput("ready_busy", 32'(req_ready), 32'h0);
    if (resp_valid) begin
      if (expQ.size() == 0 || acceptQ.size() == 0) begin
        checkOutput("unexpected_resp", 32'(resp_valid), 32'h0);
      end else begin
        exp_t e;
        int   acc;
        e   = expQ.pop_front();
        acc = acceptQ.pop_front();
        checkOutput("resp_rdata", resp_rdata, e.rdata);
        checkOutput("resp_err", 32'(resp_err), 32'(e.err));
        checkOutput("latency", cycleCount - acc + 1, e.lat);
        checkOutput("write_pulses", writeCount - writesAtLastResp, e.writes);
        writesAtLastResp = writeCount;
      end
    end
  end

  task automatic applyStimulus(input logic store, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] expRdata,
                               input logic expErr, input int expLat, input int expWrites,
                               input bit keepValid);
    int startCount;
    bit accepted;
    expQ.push_back('{expRdata, expErr, expLat, expWrites});
    @(negedge clk);
    req_valid  = 1'b1;
    req_store  = store;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    startCount = acceptCount;
    accepted   = 1'b0;
    for (int i = 0; i < 20 && !accepted; i++) begin
      @(posedge clk);
      #1;
      if (acceptCount != startCount) accepted = 1'b1;
    end
    checkOutput("accepted", 32'(accepted), 32'h1);
    if (!keepValid) req_valid = 1'b0;
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 50 && acceptQ.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    #1;
    checkOutput("drained", acceptQ.size(), 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    int base;
    for (int i = 0; i < 64; i++) ram[i] = 32'(100 + i);
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_store  = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_ready", 32'(req_ready), 32'h1);
    checkOutput("rst_resp_valid", 32'(resp_valid), 32'h0);
    checkOutput("rst_resp_err", 32'(resp_err), 32'h0);
    checkOutput("rst_resp_rdata", resp_rdata, 32'h0);
    checkOutput("rst_mem_wr_en", 32'(mem_wr_en), 32'h0);
    checkOutput("rst_mem_addr", mem_addr, 32'h0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'h0);

    $display("[TB] loads and sub-word stores");
    applyStimulus(1'b0, 3'b010, 32'h8, 32'h0, 32'h0000_0066, 1'b0, 2, 0, 1'b0);
    applyStimulus(1'b1, 3'b000, 32'h5, 32'hAB, 32'h0, 1'b0, 3, 1, 1'b0);
    waitDrain();
    checkOutput("ram_word1", ram[1], 32'h0000_AB65);
    applyStimulus(1'b0, 3'b000, 32'h5, 32'h0, 32'hFFFF_FFAB, 1'b0, 2, 0, 1'b0);
    applyStimulus(1'b0, 3'b100, 32'h5, 32'h0, 32'h0000_00AB, 1'b0, 2, 0, 1'b0);
    applyStimulus(1'b1, 3'b001, 32'hE, 32'h1234_8001, 32'h0, 1'b0, 3, 1, 1'b0);
    waitDrain();
    checkOutput("ram_word3", ram[3], 32'h8001_0067);
    applyStimulus(1'b0, 3'b001, 32'hE, 32'h0, 32'hFFFF_8001, 1'b0, 2, 0, 1'b0);
    applyStimulus(1'b0, 3'b101, 32'hE, 32'h0, 32'h0000_8001, 1'b0, 2, 0, 1'b0);
    applyStimulus(1'b0, 3'b001, 32'hC, 32'h0, 32'h0000_0067, 1'b0, 2, 0, 1'b0);
    applyStimulus(1'b1, 3'b010, 32'h1C, 32'hCAFE_F00D, 32'h0, 1'b0, 2, 1, 1'b0);
    applyStimulus(1'b0, 3'b000, 32'h1F, 32'h0, 32'hFFFF_FFCA, 1'b0, 2, 0, 1'b0);

    $display("[TB] error cases");
    applyStimulus(1'b0, 3'b010, 32'h6, 32'h0, 32'h0, 1'b1, 1, 0, 1'b0);
    applyStimulus(1'b1, 3'b001, 32'h3, 32'h5555, 32'h0, 1'b1, 1, 0, 1'b0);
    applyStimulus(1'b0, 3'b010, 32'h100, 32'h0, 32'h0, 1'b1, 1, 0, 1'b0);
    applyStimulus(1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 1'b1, 1, 0, 1'b0);
    applyStimulus(1'b1, 3'b100, 32'h4, 32'h77, 32'h0, 1'b1, 1, 0, 1'b0);
    waitDrain();
    checkOutput("ram_word0_untouched", ram[0], 32'd100);
    checkOutput("ram_word1_untouched", ram[1], 32'h0000_AB65);

    $display("[TB] reset during write");
    @(negedge clk);
    req_valid  = 1'b1;
    req_store  = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h10;
    req_wdata  = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    reset     = 1'b1;
    @(negedge clk);
    checkOutput("abort_wr_en", 32'(mem_wr_en), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    acceptQ.delete();
    @(negedge clk);
    checkOutput("abort_ready", 32'(req_ready), 32'h1);
    checkOutput("abort_resp_valid", 32'(resp_valid), 32'h0);
    checkOutput("abort_word4", ram[4], 32'd104);
    checkOutput("abort_writes", writeCount - writesAtLastResp, 0);
    repeat (3) @(negedge clk);

    $display("[TB] back-to-back with valid held");
    base = acceptLog.size();
    applyStimulus(1'b0, 3'b010, 32'h8, 32'h0, 32'h0000_0066, 1'b0, 2, 0, 1'b1);
    applyStimulus(1'b1, 3'b000, 32'h18, 32'h11, 32'h0, 1'b0, 3, 1, 1'b1);
    applyStimulus(1'b0, 3'b010, 32'h18, 32'h0, 32'h0000_0011, 1'b0, 2, 0, 1'b0);
    waitDrain();
    checkOutput("b2b_accepts", acceptLog.size() - base, 3);
    if (acceptLog.size() - base == 3) begin
      checkOutput("b2b_gap_load", acceptLog[base+1] - acceptLog[base], 3);
      checkOutput("b2b_gap_sb", acceptLog[base+2] - acceptLog[base+1], 4);
    end
    checkOutput("scoreboard_empty", expQ.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
